// File: rtl/pe_obuf_drain_if.sv
// Result stream of the PE output-buffer drain stage.
// Carries one packed vector of requantized lanes per beat, with valid/ready handshake.
interface pe_obuf_drain_if #(
  parameter int DATA_W = 256
) ();
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/pe_obuf_drain.sv
// PE output-buffer drain stage.
// Reads accumulator vectors from the obuf read port, which has 2-cycle latency. Each
// lane is requantized by rounding, shifting, optional ReLU and saturation. Results are
// streamed out through a small result FIFO. Reads are issued only when the FIFO has
// room for them, counting reads still in flight, so back-pressure never loses data.

// Overflow guard for the result FIFO. A push while the FIFO is full means the credit
// logic is broken.
module pe_obuf_drain_chk (
  input logic clk,
  input logic rst_n,
  input logic i_push,
  input logic i_full
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && i_full));
endmodule

module pe_obuf_drain #(
  parameter  int SUBARRAY_ROWS = 32,
  parameter  int OUTPUT_WIDTH  = 32,
  parameter  int QUANT_WIDTH   = 8,
  parameter  int BUF_DEPTH     = 4,
  parameter  int FIFO_DEPTH    = 4,
  parameter  int CNT_WIDTH     = 8,
  localparam int AW            = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [AW-1:0]                         base_addr,
  input  logic [CNT_WIDTH-1:0]                  num_vecs,
  input  logic [4:0]                            shift,
  input  logic                                  relu_en,
  output logic                                  busy,
  output logic                                  done,
  output logic [AW-1:0]                         obuf_rd_addr,
  output logic                                  obuf_rd_en,
  input  logic [SUBARRAY_ROWS*OUTPUT_WIDTH-1:0] obuf_rd_data,
  pe_obuf_drain_if.master                       out_if
);

  localparam int SR  = SUBARRAY_ROWS;
  localparam int OW  = OUTPUT_WIDTH;
  localparam int QW  = QUANT_WIDTH;
  localparam int QDW = SR * QW;
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  // Saturation bounds in the (OW+1)-bit intermediate domain. ~max equals the minimum
  // value in two's complement.
  localparam logic signed [OW:0] QMAX = (OW+1)'((32'sd1 <<< (QW - 1)) - 32'sd1);
  localparam logic signed [OW:0] QMIN = ~QMAX;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Requantize one lane. The one extra bit means the rounding addend cannot overflow.
  function automatic logic [QW-1:0] requant(input logic [OW-1:0] acc,
                                            input logic [4:0]    sh,
                                            input logic          relu);
    logic signed [OW:0] v_ext;
    logic signed [OW:0] v_half;
    logic signed [OW:0] v_res;
    logic [QW-1:0]      v_out;
    v_ext  = $signed({acc[OW-1], acc});
    v_half = '0;
    if (sh != 5'd0) begin
      v_half = {{OW{1'b0}}, 1'b1} << (sh - 5'd1);
      v_res  = (v_ext + v_half) >>> sh;
    end else begin
      v_res  = v_ext;
    end
    if (relu && v_res[OW]) begin
      v_res = '0;
    end else begin
      v_res = v_res;
    end
    if (v_res > QMAX) begin
      v_out = QMAX[QW-1:0];
    end else if (v_res < QMIN) begin
      v_out = QMIN[QW-1:0];
    end else begin
      v_out = v_res[QW-1:0];
    end
    return v_out;
  endfunction

  // Advance a FIFO pointer with explicit wrap, so the depth need not be a power of two.
  function automatic logic [FAW-1:0] ptr_inc(input logic [FAW-1:0] p);
    return (p == FAW'(FIFO_DEPTH - 1)) ? '0 : p + FAW'(1);
  endfunction

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_num;
  logic [CNT_WIDTH-1:0] r_issued;
  logic [4:0]           r_shift;
  logic                 r_relu;
  logic [AW-1:0]        r_addr;
  logic [1:0]           r_vld;
  logic [1:0]           r_lst;
  logic [FAW-1:0]       r_wr_ptr;
  logic [FAW-1:0]       r_rd_ptr;
  logic [FCW-1:0]       r_count;
  logic [QDW-1:0]       r_fifo_data [FIFO_DEPTH];
  logic                 r_fifo_last [FIFO_DEPTH];

  logic [1:0]           w_in_flight;
  logic [FCW:0]         w_occupancy;
  logic                 w_credit;
  logic                 w_issue;
  logic                 w_issue_last;
  logic                 w_push;
  logic                 w_valid;
  logic                 w_pop;
  logic                 w_head_last;
  logic                 w_full;
  logic [QDW-1:0]       w_quant;

  // Reads are allowed only while the FIFO still has room for every outstanding vector.
  assign w_in_flight  = {1'b0, r_vld[0]} + {1'b0, r_vld[1]};
  assign w_occupancy  = {1'b0, r_count} + {{(FCW-1){1'b0}}, w_in_flight};
  assign w_credit     = (w_occupancy < (FCW+1)'(FIFO_DEPTH));
  assign w_issue      = (r_state == S_RUN) && (r_issued != r_num) && w_credit;
  assign w_issue_last = w_issue && (r_issued == (r_num - CNT_WIDTH'(1)));

  assign w_push       = r_vld[1];
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid && out_if.out_ready;
  assign w_head_last  = r_fifo_last[r_rd_ptr];
  assign w_full       = (r_count == FCW'(FIFO_DEPTH));

  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_DONE);
  assign obuf_rd_en        = w_issue;
  assign obuf_rd_addr      = r_addr;
  assign out_if.out_valid  = w_valid;
  assign out_if.out_data   = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign out_if.out_last   = w_valid && w_head_last;

  // Next-state logic of the job sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_vecs == '0) ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_issue_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_pop && w_head_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the job configuration on an accepted start; step the read index and wrap the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num    <= '0;
      r_issued <= '0;
      r_shift  <= 5'd0;
      r_relu   <= 1'b0;
      r_addr   <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_num    <= num_vecs;
      r_issued <= '0;
      r_shift  <= shift;
      r_relu   <= relu_en;
      r_addr   <= base_addr;
    end else if (w_issue) begin
      r_issued <= r_issued + CNT_WIDTH'(1);
      r_addr   <= (r_addr == AW'(BUF_DEPTH - 1)) ? '0 : r_addr + AW'(1);
    end
  end

  // Track reads in flight, aligned to the read latency, together with their last-vector tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 2'b00;
      r_lst <= 2'b00;
    end else begin
      r_vld <= {r_vld[0], w_issue};
      r_lst <= {r_lst[0], w_issue_last};
    end
  end

  // Requantize every lane of the returning vector.
  always_comb begin
    w_quant = '0;
    for (int i = 0; i < SR; i++) begin
      w_quant[i*QW +: QW] = requant(obuf_rd_data[i*OW +: OW], r_shift, r_relu);
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCW'(1);
        2'b01:   r_count <= r_count - FCW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; the head is masked while the FIFO is empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_quant;
      r_fifo_last[r_wr_ptr] <= r_lst[1];
    end
  end

  pe_obuf_drain_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_full (w_full)
  );

endmodule

// File: tb/tb_pe_obuf_drain.sv
// Self-checking bench for pe_obuf_drain. Each job start pushes the expected read
// addresses and result beats into queues. A negedge monitor pops those queues and
// compares them against the read port and the output stream.
module tb_pe_obuf_drain;
  localparam int SR = 32;
  localparam int OW = 32;
  localparam int QW = 8;
  localparam int BD = 4;
  localparam int FD = 4;
  localparam int CW = 8;
  localparam int AW = 2;

  typedef struct {
    logic [SR*QW-1:0] d;
    logic             l;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [CW-1:0]        num_vecs;
  logic [4:0]           shift;
  logic                 relu_en;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        obuf_rd_addr;
  logic                 obuf_rd_en;
  logic [SR*OW-1:0]     obuf_rd_data;
  logic [SR*OW-1:0]     obuf_pipe;
  logic [SR*OW-1:0]     mem [BD];

  pe_obuf_drain_if #(.DATA_W(SR*QW)) out_if ();

  pe_obuf_drain #(
    .SUBARRAY_ROWS(SR), .OUTPUT_WIDTH(OW), .QUANT_WIDTH(QW),
    .BUF_DEPTH(BD), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_vecs     (num_vecs),
    .shift        (shift),
    .relu_en      (relu_en),
    .busy         (busy),
    .done         (done),
    .obuf_rd_addr (obuf_rd_addr),
    .obuf_rd_en   (obuf_rd_en),
    .obuf_rd_data (obuf_rd_data),
    .out_if       (out_if)
  );

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            exp_done_cyc = -1;
  int            first_valid_cyc = -1;
  bit            seen_valid = 1'b0;
  bit            ready_rand = 1'b0;
  int            n_issued = 0;
  int            n_accepted = 0;
  bit            held_v = 1'b0;
  logic [SR*QW-1:0] held_d;
  logic          held_l;
  logic [AW-1:0] addr_q [$];
  beat_t         exp_q [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // obuf port-B model: data appears two cycles after the read enable.
  always @(posedge clk) begin
    obuf_pipe    <= obuf_rd_en ? mem[obuf_rd_addr] : '0;
    obuf_rd_data <= obuf_pipe;
  end

  task automatic chk(input string nm, input logic [SR*QW-1:0] act, input logic [SR*QW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference requantization: round half up, arithmetic shift, ReLU, clamp to int8.
  function automatic logic [QW-1:0] ref_q(input int acc, input int sh, input bit rl);
    longint v;
    v = acc;
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (rl && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v[QW-1:0];
  endfunction

  function automatic logic [SR*QW-1:0] ref_vec(input logic [SR*OW-1:0] m, input int sh, input bit rl);
    logic [SR*QW-1:0] r;
    r = '0;
    for (int j = 0; j < SR; j++) r[j*QW +: QW] = ref_q(int'($signed(m[j*OW +: OW])), sh, rl);
    return r;
  endfunction

  // Monitor: read-port order and credit, done timing, beat order and stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (obuf_rd_en) begin
        if (addr_q.size() == 0) chk("unexpected_read", 256'(obuf_rd_addr), 256'(1'b0) - 256'd1);
        else chk("rd_addr", 256'(obuf_rd_addr), 256'(addr_q.pop_front()));
        n_issued++;
        n_chk++;
        if (n_issued - n_accepted > FD) begin
          n_fail++;
          $display("FAIL rd_credit: outstanding %0d exceeds %0d", n_issued - n_accepted, FD);
        end
      end
      chk("done", 256'(done), 256'(cyc == exp_done_cyc));
      if (out_if.out_valid) begin
        if (!seen_valid) begin
          seen_valid      = 1'b1;
          first_valid_cyc = cyc;
        end
        if (held_v) begin
          chk("stall_data", out_if.out_data, held_d);
          chk("stall_last", 256'(out_if.out_last), 256'(held_l));
        end
        if (out_if.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", out_if.out_data, ~out_if.out_data);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_data", out_if.out_data, e.d);
            chk("beat_last", 256'(out_if.out_last), 256'(e.l));
            if (e.l) exp_done_cyc = cyc + 1;
          end
          n_accepted++;
        end
      end
      held_v = out_if.out_valid && !out_if.out_ready;
      held_d = out_if.out_data;
      held_l = out_if.out_last;
    end else begin
      held_v = 1'b0;
    end
  end

  // Consumer ready: constant 1 or random per cycle.
  initial begin
    out_if.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_if.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic fill_const(input int v);
    for (int a = 0; a < BD; a++)
      for (int j = 0; j < SR; j++) mem[a][j*OW +: OW] = v;
  endtask

  task automatic fill_pattern();
    int pat [4] = '{-300, 40000, 7, -7};
    for (int a = 0; a < BD; a++)
      for (int j = 0; j < SR; j++) mem[a][j*OW +: OW] = pat[j % 4];
  endtask

  task automatic fill_rand();
    for (int a = 0; a < BD; a++)
      for (int j = 0; j < SR; j++)
        mem[a][j*OW +: OW] = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom_range(0, 800) - 400);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},  256'(busy), 256'(1'b0));
    chk({tag, "_done"},  256'(done), 256'(1'b0));
    chk({tag, "_rd_en"}, 256'(obuf_rd_en), 256'(1'b0));
    chk({tag, "_rd_addr"}, 256'(obuf_rd_addr), 256'(1'b0));
    chk({tag, "_valid"}, 256'(out_if.out_valid), 256'(1'b0));
    chk({tag, "_data"},  out_if.out_data, 256'(1'b0));
    chk({tag, "_last"},  256'(out_if.out_last), 256'(1'b0));
  endtask

  // Launch one job: queue expected reads and beats, pulse start, then wait for done.
  task automatic run_job(input int b, input int n, input int sh, input bit rl,
                         input bit extra, input bit chk_lat);
    int sc;
    bit got;
    for (int i = 0; i < n; i++) begin
      int    a;
      beat_t e;
      a   = (b + i) % BD;
      addr_q.push_back(a[AW-1:0]);
      e.d = ref_vec(mem[a], sh, rl);
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b[AW-1:0]; num_vecs = n[CW-1:0]; shift = sh[4:0]; relu_en = rl;
    sc = cyc;
    seen_valid = 1'b0;
    if (n == 0) exp_done_cyc = sc + 1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); num_vecs = CW'($urandom); shift = 5'($urandom);
    relu_en = 1'($urandom);
    if (extra) begin
      @(posedge clk); #1;
      start = 1'b1; num_vecs = 8'd3; base_addr = 2'd1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk("job_done_seen", 256'(got), 256'(1'b1));
    if (chk_lat) chk("first_valid_latency", 256'(first_valid_cyc - sc), 256'd4);
    if (n == 0) chk("no_valid_on_empty_job", 256'(seen_valid), 256'(1'b0));
    @(negedge clk);
    chk("idle_after_done", 256'(busy), 256'(1'b0));
    chk("beats_left", 256'(exp_q.size()), 256'd0);
    chk("reads_left", 256'(addr_q.size()), 256'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_vecs = '0; shift = 5'd0; relu_en = 1'b0;
    fill_const(0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk); #1 rst_n = 1'b1;

    // Uniform +1000 lanes, shift 4: every lane rounds to 63; first beat four cycles after start.
    fill_const(1000);
    run_job(0, 4, 4, 1'b0, 1'b0, 1'b1);

    // Saturation and ReLU on a mixed-sign lane pattern.
    fill_pattern();
    run_job(0, 4, 0, 1'b0, 1'b0, 1'b1);
    run_job(0, 4, 0, 1'b1, 1'b0, 1'b0);

    // Address wrap from base 3.
    fill_rand();
    run_job(3, 3, 5, 1'b0, 1'b0, 1'b0);

    // Random back-pressure, with an ignored start while busy.
    ready_rand = 1'b1;
    fill_rand();
    run_job(1, 8, $urandom_range(0, 31), 1'($urandom), 1'b1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      fill_rand();
      run_job($urandom_range(0, 3), $urandom_range(5, 12), $urandom_range(0, 31),
              1'($urandom), 1'b0, 1'b0);
    end
    ready_rand = 1'b0;

    // Empty job.
    run_job(2, 0, 3, 1'b0, 1'b0, 1'b0);

    // Reset with two reads in flight, then a clean job.
    fill_rand();
    for (int i = 0; i < 8; i++) addr_q.push_back(AW'(i % BD));
    @(posedge clk); #1;
    start = 1'b1; base_addr = 2'd0; num_vecs = 8'd8; shift = 5'd2; relu_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    addr_q.delete();
    exp_q.delete();
    n_issued = 0;
    n_accepted = 0;
    exp_done_cyc = -1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    ready_rand = 1'b1;
    fill_rand();
    run_job(2, 6, 7, 1'b1, 1'b1, 1'b0);
    ready_rand = 1'b0;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
